bird_flight_ctrl: RTL and testbench
===================================

# bird_flight_ctrl

Per-tick vertical physics engine for the bird sprite. It consumes the debounced flap pulse (`SCEN` from `ee201_debouncer`) and the collision flag from the obstacle checker. It produces the registered bird position and vertical speed consumed by `obstacle_logic` and `vga_output`. It also owns the bird's life-cycle state: idle, flying, falling after a hit, and dead.

## Interface
Parameters:
- `TICK_DIV`, 1_000_000: `Clk` cycles per physics tick; minimum 2.
- `X_POS`, 200: constant bird X position.
- `Y_INIT`, 240: Y loaded at reset and on `Ack`.
- `Y_MIN`, 0: ceiling Y.
- `Y_MAX`, 464: floor Y.
- `GRAVITY`, 1: speed increment per tick.
- `FLAP_VEL`, -8: signed speed loaded on flap.
- `V_MAX`, 10: terminal downward speed.

Ports:
- `Clk` in 1: the single clock.
- `reset` in 1: synchronous reset, active-low.
- `Start` in 1: level; begins flight from IDLE.
- `Ack` in 1: level; returns DEAD to IDLE.
- `BtnPress` in 1: one-cycle flap pulse.
- `Hit` in 1: level; pipe collision reported by obstacle logic.
- `Bird_X` out 10: equals `X_POS`.
- `Bird_Y` out 10, signed: current Y; larger values are lower on screen.
- `VertSpeed` out 10, signed: current speed in pixels per tick; positive is downward.
- `Flying` out 1: high in FLY.
- `Dead` out 1: high in DEAD.
- `Tick` out 1: one-cycle pulse on each physics update.

## Operation
- States:
  - IDLE: no motion; tick counter held at 0.
  - FLY: gravity and flaps applied every tick.
  - FALL: gravity only; flaps ignored.
  - DEAD: frozen.
- Transitions:
  - IDLE→FLY on `Start`.
  - FLY→FALL on `Hit`.
  - FLY→DEAD when the floor is reached.
  - FALL→DEAD when the floor is reached.
  - DEAD→IDLE on `Ack`.
  - `Start` is ignored outside IDLE. `Ack` is ignored outside DEAD. `Hit` is ignored outside FLY.
- Tick counter: counts 0..`TICK_DIV`-1 in FLY and FALL; the tick fires when the count equals `TICK_DIV`-1, then the counter wraps to 0.
- Flap latch: set by `BtnPress` in FLY. It holds across any number of pulses and is cleared on each tick. It is also cleared on leaving FLY.
- Per-tick update, with 11-bit signed intermediates:
  - Speed: `v' = flap ? FLAP_VEL : min(v + GRAVITY, V_MAX)`.
  - Position: `y' = y + v'`.
- Floor: if `y' >= Y_MAX`, then `Bird_Y = Y_MAX`, `VertSpeed = 0`, and the state becomes DEAD.
- Ceiling: if `y' < Y_MIN`, then `Bird_Y = Y_MIN` and `VertSpeed = 0`; the state is unchanged (see Configuration).
- Ack reload: entering IDLE from DEAD loads `Bird_Y = Y_INIT` and `VertSpeed = 0`, and clears the counter and latch.

## Timing
- Reset values (while `reset` = 0 at an edge):
  - State IDLE.
  - `Bird_Y = Y_INIT`.
  - `VertSpeed = 0`.
  - `Bird_X = X_POS`.
  - `Flying`, `Dead`, `Tick` = 0.
  - Counter and flap latch cleared.
- Reset mid-flight aborts everything in that cycle; reset overrides all other inputs.
- All outputs are registered:
  - `Start` sampled at edge N gives `Flying` = 1 after edge N.
  - The first tick occurs `TICK_DIV` cycles later.
- On the tick edge, `Bird_Y`, `VertSpeed` and `Tick` update together, and `Dead` rises on the same edge as the floor clamp.
- A `BtnPress` coincident with the tick edge is applied on that tick.
- A `Hit` and a tick on the same edge: the hit wins. The state goes to FALL, and that tick is applied with gravity only; any pending flap is discarded.
- A `Hit` in the same cycle as the floor-reaching tick: the result is DEAD.
- `Ack` and `Start` held high together in DEAD: the block goes to IDLE, then to FLY on the next edge.

## Configuration
- `BIRD_CEILING_KILL_EN`
  - Defined: a tick with `y' < Y_MIN` in FLY clamps to `Y_MIN` and forces FLY→FALL, so the bird then drops to the floor.
  - Undefined: the ceiling only clamps (`Bird_Y = Y_MIN`, `VertSpeed = 0`), and flight continues.

## Test plan
All scenarios use `TICK_DIV` = 4 and other parameters at their defaults.
- Reset with `reset` = 0 for 2 cycles → `Bird_Y` = 240, `VertSpeed` = 0, `Bird_X` = 200, `Flying` = 0, `Dead` = 0; `Start` pulse → `Flying` = 1 next edge, first `Tick` 4 cycles later.
- Free fall → `VertSpeed` 1,2,3…10,10 on successive ticks; `Bird_Y` 241,243,246,250…; speed saturates at 10.
- Flap: two `BtnPress` pulses between ticks at speed 5 → next tick `VertSpeed` = -8 and `Bird_Y` decreases by 8; the following tick gives `VertSpeed` = -7.
- Floor: free fall from 240 → the tick where `y'` ≥ 464 gives `Bird_Y` = 464, `VertSpeed` = 0, `Dead` = 1, `Flying` = 0; `Ack` → IDLE with `Bird_Y` = 240.
- Hit and flap on the same tick edge → state FALL, flap ignored, speed = previous+1; subsequent `BtnPress` has no effect; the bird reaches 464 and goes DEAD; a `reset` pulse mid-FALL restores the reset values.
- Ceiling: flap repeatedly from `Y_INIT` = 20 → `Bird_Y` clamps at 0 with `VertSpeed` 0.
  - Macro undefined: `Flying` stays 1.
  - `BIRD_CEILING_KILL_EN` defined: the state enters FALL and ends DEAD at 464.

Source files
------------

// File: rtl/bird_flight_ctrl.sv
`default_nettype none
// bird_flight_ctrl: per-tick vertical physics and idle/fly/fall/dead life cycle of the bird.
// Optional macro BIRD_CEILING_KILL_EN: a ceiling strike while flying forces the fall state.
module bird_flight_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter int X_POS    = 200,
  parameter int Y_INIT   = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 464,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int V_MAX    = 10
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              BtnPress,
  input  logic              Hit,
  output logic [9:0]        Bird_X,
  output logic signed [9:0] Bird_Y,
  output logic signed [9:0] VertSpeed,
  output logic              Flying,
  output logic              Dead,
  output logic              Tick
);

  localparam int c_cw = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0]    c_cnt_max  = c_cw'(TICK_DIV - 1);
  localparam logic [9:0]         c_x_pos    = 10'(X_POS);
  localparam logic signed [9:0]  c_y_init   = 10'(Y_INIT);
  localparam logic signed [10:0] c_y_min    = 11'(Y_MIN);
  localparam logic signed [10:0] c_y_max    = 11'(Y_MAX);
  localparam logic signed [10:0] c_grav     = 11'(GRAVITY);
  localparam logic signed [10:0] c_flap_vel = 11'(FLAP_VEL);
  localparam logic signed [10:0] c_v_max    = 11'(V_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_FALL = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_cw-1:0]        r_cnt;
  logic [c_cw-1:0]        w_cnt_nxt;
  logic                   r_flap;
  logic                   w_flap_nxt;
  logic signed [9:0]      r_y;
  logic signed [9:0]      w_y_nxt;
  logic signed [9:0]      r_v;
  logic signed [9:0]      w_v_nxt;
  logic                   r_tick;
  logic                   w_tick_nxt;

  logic                   w_run;
  logic                   w_tick;
  logic                   w_flap_apply;
  logic signed [10:0]     w_v_grav;
  logic signed [10:0]     w_v_sat;
  logic signed [10:0]     w_v_new;
  logic signed [10:0]     w_y_new;
  logic                   w_floor;
  logic                   w_ceil;

  assign w_run  = (r_state == S_FLY) || (r_state == S_FALL);
  assign w_tick = w_run && (r_cnt == c_cnt_max);

  // A hit on the tick edge discards any pending flap: that tick is gravity only.
  assign w_flap_apply = (r_state == S_FLY) && !Hit && (r_flap || BtnPress);

  assign w_v_grav = $signed({r_v[9], r_v}) + c_grav;
  assign w_v_sat  = (w_v_grav > c_v_max) ? c_v_max : w_v_grav;
  assign w_v_new  = w_flap_apply ? c_flap_vel : w_v_sat;
  assign w_y_new  = $signed({r_y[9], r_y}) + w_v_new;
  assign w_floor  = (w_y_new >= c_y_max);
  assign w_ceil   = (w_y_new < c_y_min);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flap_nxt  = r_flap;
    w_y_nxt     = r_y;
    w_v_nxt     = r_v;
    w_tick_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_flap_nxt = 1'b0;
        if (Start) begin
          w_state_nxt = S_FLY;
        end
      end

      S_FLY, S_FALL: begin
        w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        if (r_state == S_FLY) begin
          w_flap_nxt = r_flap || BtnPress;
        end

        if (w_tick) begin
          w_tick_nxt = 1'b1;
          w_flap_nxt = 1'b0;
          w_v_nxt    = w_v_new[9:0];
          w_y_nxt    = w_y_new[9:0];
          if (w_floor) begin
            w_y_nxt     = c_y_max[9:0];
            w_v_nxt     = '0;
            w_state_nxt = S_DEAD;
          end else if (w_ceil) begin
            w_y_nxt = c_y_min[9:0];
            w_v_nxt = '0;
`ifdef BIRD_CEILING_KILL_EN
            if (r_state == S_FLY) begin
              w_state_nxt = S_FALL;
            end
`endif
          end
        end

        // Reaching the floor outranks a simultaneous hit.
        if ((r_state == S_FLY) && Hit && !(w_tick && w_floor)) begin
          w_state_nxt = S_FALL;
        end

        if (w_state_nxt != S_FLY) begin
          w_flap_nxt = 1'b0;
        end
      end

      S_DEAD: begin
        w_cnt_nxt  = '0;
        w_flap_nxt = 1'b0;
        if (Ack) begin
          w_state_nxt = S_IDLE;
          w_y_nxt     = c_y_init;
          w_v_nxt     = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_flap_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_flap  <= 1'b0;
      r_y     <= c_y_init;
      r_v     <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flap  <= w_flap_nxt;
      r_y     <= w_y_nxt;
      r_v     <= w_v_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign Bird_X    = c_x_pos;
  assign Bird_Y    = r_y;
  assign VertSpeed = r_v;
  assign Flying    = (r_state == S_FLY);
  assign Dead      = (r_state == S_DEAD);
  assign Tick      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_bird_flight_ctrl.sv
`default_nettype none
// Scoreboard bench for bird_flight_ctrl: expected tick results are queued, a monitor checks each Tick.
module tb_bird_flight_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic reset = 1'b0;
  logic Start = 1'b0;
  logic Ack = 1'b0;
  logic BtnPress = 1'b0;
  logic Hit = 1'b0;

  logic [9:0]        x1, x2;
  logic signed [9:0] y1, y2, v1, v2;
  logic              fly1, fly2, dead1, dead2, tick1, tick2;

  bird_flight_ctrl #(.TICK_DIV(4)) u_dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .BtnPress(BtnPress), .Hit(Hit),
    .Bird_X(x1), .Bird_Y(y1), .VertSpeed(v1), .Flying(fly1), .Dead(dead1), .Tick(tick1)
  );

  bird_flight_ctrl #(.TICK_DIV(4), .Y_INIT(20)) u_dut_ceil (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .BtnPress(BtnPress), .Hit(Hit),
    .Bird_X(x2), .Bird_Y(y2), .VertSpeed(v2), .Flying(fly2), .Dead(dead2), .Tick(tick2)
  );

  typedef struct {
    int y;
    int v;
    bit fly;
    bit dead;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sel     = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int y, input int v, input bit fly, input bit dead);
    exp_t e;
    e.y = y; e.v = v; e.fly = fly; e.dead = dead;
    exp_q.push_back(e);
  endtask

  // Gravity-only descent from (y0, v0) until the floor; returns number of ticks queued.
  task automatic push_gravity(input int y0, input int v0, input bit fly, output int n);
    int y;
    int v;
    y = y0; v = v0; n = 0;
    while (y < 464) begin
      v = (v + 1 > 10) ? 10 : v + 1;
      y = y + v;
      n++;
      if (y >= 464) push(464, 0, 1'b0, 1'b1);
      else          push(y, v, fly, 1'b0);
    end
  endtask

  // Monitor: every Tick of the selected DUT consumes one expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (sel ? tick2 : tick1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_y",    sel ? int'(y2) : int'(y1), e.y);
        chk("tick_v",    sel ? int'(v2) : int'(v1), e.v);
        chk("tick_fly",  sel ? int'(fly2) : int'(fly1), int'(e.fly));
        chk("tick_dead", sel ? int'(dead2) : int'(dead1), int'(e.dead));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      cyc(1);
      n++;
      seen = sel ? tick2 : tick1;
    end
    if (!seen) chk("tick_timeout", 0, 1);
  endtask

  task automatic ticks(input int k);
    int n;
    repeat (k) wait_tick(n);
  endtask

  int n_lat;
  int n_fall;

  initial begin
    // Reset values
    reset = 1'b0;
    cyc(2);
    chk("rst_y", int'(y1), 240);
    chk("rst_v", int'(v1), 0);
    chk("rst_x", int'(x1), 200);
    chk("rst_fly", int'(fly1), 0);
    chk("rst_dead", int'(dead1), 0);
    chk("rst_tick", int'(tick1), 0);
    reset = 1'b1;
    cyc(1);

    // Start, first-tick latency, free fall to speed 5
    push(241, 1, 1, 0); push(243, 2, 1, 0); push(246, 3, 1, 0);
    push(250, 4, 1, 0); push(255, 5, 1, 0);
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    chk("start_fly", int'(fly1), 1);
    wait_tick(n_lat);
    chk("first_tick_latency", n_lat, 4);
    ticks(4);

    // Two flap pulses between ticks
    push(247, -8, 1, 0); push(240, -7, 1, 0);
    BtnPress = 1'b1; cyc(1);
    BtnPress = 1'b0; cyc(1);
    BtnPress = 1'b1; cyc(1);
    BtnPress = 1'b0;
    ticks(2);

    // Hit and flap on the same tick edge: gravity only, enter FALL
    push(234, -6, 0, 0);
    cyc(3);
    Hit = 1'b1; BtnPress = 1'b1;
    ticks(1);
    Hit = 1'b0; BtnPress = 1'b0;
    chk("hit_fly", int'(fly1), 0);
    push(229, -5, 0, 0);
    BtnPress = 1'b1; cyc(1);
    BtnPress = 1'b0;
    ticks(1);

    // Reset mid-FALL
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("midrst_y", int'(y1), 240);
    chk("midrst_v", int'(v1), 0);
    chk("midrst_fly", int'(fly1), 0);
    chk("midrst_tick", int'(tick1), 0);
    cyc(1);

    // Free fall from 240 to the floor in FLY, speed saturating at 10
    push_gravity(240, 0, 1'b1, n_fall);
    chk("fall_tick_count", n_fall, 27);
    Start = 1'b1; cyc(1); Start = 1'b0;
    ticks(n_fall);
    chk("floor_dead", int'(dead1), 1);
    chk("floor_fly", int'(fly1), 0);
    chk("floor_y", int'(y1), 464);
    Start = 1'b1; Hit = 1'b1; BtnPress = 1'b1;
    cyc(8);
    Start = 1'b0; Hit = 1'b0; BtnPress = 1'b0;
    chk("dead_frozen_y", int'(y1), 464);
    chk("dead_frozen_dead", int'(dead1), 1);
    Ack = 1'b1; cyc(1); Ack = 1'b0;
    chk("ack_y", int'(y1), 240);
    chk("ack_v", int'(v1), 0);
    chk("ack_dead", int'(dead1), 0);

    // Hit ignored in IDLE; hit between ticks in FLY, then fall to the floor in FALL
    Hit = 1'b1; cyc(2); Hit = 1'b0;
    chk("idle_hit_fly", int'(fly1), 0);
    chk("idle_hit_dead", int'(dead1), 0);
    Start = 1'b1; cyc(1); Start = 1'b0;
    Hit = 1'b1; cyc(1); Hit = 1'b0;
    chk("fall_state_fly", int'(fly1), 0);
    push_gravity(240, 0, 1'b0, n_fall);
    ticks(n_fall);
    chk("fall_dead", int'(dead1), 1);

    // Ack and Start together in DEAD: IDLE, then FLY
    Ack = 1'b1; Start = 1'b1;
    cyc(1);
    chk("ackstart_idle_fly", int'(fly1), 0);
    chk("ackstart_idle_dead", int'(dead1), 0);
    chk("ackstart_idle_y", int'(y1), 240);
    cyc(1);
    Ack = 1'b0; Start = 1'b0;
    chk("ackstart_fly", int'(fly1), 1);

    // Ceiling on the Y_INIT=20 instance with the flap held
    reset = 1'b0; cyc(1); reset = 1'b1;
    sel = 1'b1;
    chk("ceil_rst_y", int'(y2), 20);
    push(12, -8, 1, 0); push(4, -8, 1, 0);
`ifdef BIRD_CEILING_KILL_EN
    push(0, 0, 0, 0);
    push_gravity(0, 0, 1'b0, n_fall);
    n_fall = n_fall + 3;
`else
    push(0, 0, 1, 0); push(0, 0, 1, 0);
    n_fall = 4;
`endif
    BtnPress = 1'b1;
    Start = 1'b1; cyc(1); Start = 1'b0;
    ticks(n_fall);
    BtnPress = 1'b0;
`ifdef BIRD_CEILING_KILL_EN
    chk("ceil_kill_dead", int'(dead2), 1);
    chk("ceil_kill_y", int'(y2), 464);
`else
    chk("ceil_fly", int'(fly2), 1);
    chk("ceil_y", int'(y2), 0);
`endif

    cyc(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
